// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the framed serial receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Line input and word-output handshake bundle for serial_frame_rx.
interface serial_frame_rx_if #(
    parameter int unsigned W = 8
);
    logic         serial_in;
    logic         bit_valid;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;
    logic         overrun_clr;

    modport master (
        output serial_in, bit_valid, data_ready, overrun_clr,
        input  data_out, data_valid, frame_err, parity_err, overrun
    );

    modport slave (
        input  serial_in, bit_valid, data_ready, overrun_clr,
        output data_out, data_valid, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, W data bits LSB first, optional even
// parity, stop bit; good words land in a one-entry valid/ready buffer.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    serial_frame_rx_if.slave bus
);

    localparam int unsigned   CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          ovr_q, ovr_d;
    logic          drain;

    assign drain = valid_q && bus.data_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = drain ? 1'b0 : valid_q;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        ovr_d   = bus.overrun_clr ? 1'b0 : ovr_q;

        if (bus.bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.serial_in == START_LVL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d[cnt_q] = bus.serial_in;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_d   = bus.serial_in;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // Stop-bit failure outranks parity; only clean frames reach the buffer.
                    if (bus.serial_in != STOP_LVL) begin
                        ferr_d = 1'b1;
                    end else if (PARITY_EN && (^{shreg_q, par_q})) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || drain) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with W=8 and even parity enabled.
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    serial_frame_rx_if #(.W(8)) bus ();

    serial_frame_rx #(.W(8), .PARITY_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.bit_valid = 1'b0;
                bus.serial_in = $urandom_range(0, 1);
                tick();
            end
        end
        bus.serial_in = b;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        bus.serial_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input bit gaps, input bit ready_at_stop, input bit clr_at_stop);
        send_bit(1'b0, gaps);
        for (int i = 0; i < 8; i++) send_bit(d[i], gaps);
        send_bit((^d) ^ par_flip, gaps);
        bus.data_ready  = ready_at_stop;
        bus.overrun_clr = clr_at_stop;
        send_bit(stop, gaps);
        bus.data_ready  = 1'b0;
        bus.overrun_clr = 1'b0;
    endtask

    task automatic drain_word();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.serial_in = 1'b1;
        bus.bit_valid = 1'b0;
        bus.data_ready = 1'b0;
        bus.overrun_clr = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({bus.data_out, bus.data_valid, bus.frame_err, bus.parity_err, bus.overrun} !== 12'h000)
            $display("FAIL reset_outputs: got %h want 000",
                     {bus.data_out, bus.data_valid, bus.frame_err, bus.parity_err, bus.overrun});
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5)
            $display("FAIL good_frame: valid=%b data=%h want 1/a5", bus.data_valid, bus.data_out);
        else n_pass++;
        n_total++;
        if (bus.frame_err !== 1'b0 || bus.parity_err !== 1'b0)
            $display("FAIL good_frame_errs: ferr=%b perr=%b want 0/0", bus.frame_err, bus.parity_err);
        else n_pass++;
        tick();
        n_total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5)
            $display("FAIL hold_no_ready: valid=%b data=%h want 1/a5", bus.data_valid, bus.data_out);
        else n_pass++;
        drain_word();
        n_total++;
        if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5)
            $display("FAIL drain: valid=%b data=%h want 0/a5", bus.data_valid, bus.data_out);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (bus.frame_err !== 1'b1 || bus.parity_err !== 1'b0 || bus.data_valid !== 1'b0)
            $display("FAIL frame_err_pulse: ferr=%b perr=%b valid=%b want 1/0/0",
                     bus.frame_err, bus.parity_err, bus.data_valid);
        else n_pass++;
        tick();
        n_total++;
        if (bus.frame_err !== 1'b0)
            $display("FAIL frame_err_width: ferr=%b want 0", bus.frame_err);
        else n_pass++;
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h01)
            $display("FAIL after_frame_err: valid=%b data=%h want 1/01", bus.data_valid, bus.data_out);
        else n_pass++;
        drain_word();
    endtask

    task automatic test_parity_err();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (bus.parity_err !== 1'b1 || bus.frame_err !== 1'b0 || bus.data_valid !== 1'b0)
            $display("FAIL parity_err_pulse: perr=%b ferr=%b valid=%b want 1/0/0",
                     bus.parity_err, bus.frame_err, bus.data_valid);
        else n_pass++;
        tick();
        n_total++;
        if (bus.parity_err !== 1'b0 || bus.data_valid !== 1'b0)
            $display("FAIL parity_err_width: perr=%b valid=%b want 0/0", bus.parity_err, bus.data_valid);
        else n_pass++;
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (bus.data_out !== 8'h11 || bus.data_valid !== 1'b1 || bus.overrun !== 1'b1)
            $display("FAIL overrun_set: data=%h valid=%b ovr=%b want 11/1/1",
                     bus.data_out, bus.data_valid, bus.overrun);
        else n_pass++;
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        n_total++;
        if (bus.overrun !== 1'b0)
            $display("FAIL overrun_clr: ovr=%b want 0", bus.overrun);
        else n_pass++;
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (bus.overrun !== 1'b1 || bus.data_out !== 8'h11)
            $display("FAIL overrun_set_wins: ovr=%b data=%h want 1/11", bus.overrun, bus.data_out);
        else n_pass++;
        bus.overrun_clr = 1'b1;
        drain_word();
        bus.overrun_clr = 1'b0;
    endtask

    task automatic test_simultaneous_drain();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (bus.data_out !== 8'h22 || bus.data_valid !== 1'b1 || bus.overrun !== 1'b0)
            $display("FAIL simul_drain: data=%h valid=%b ovr=%b want 22/1/0",
                     bus.data_out, bus.data_valid, bus.overrun);
        else n_pass++;
        drain_word();
    endtask

    task automatic test_gaps_and_reset();
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hFF)
            $display("FAIL gapped_frame: valid=%b data=%h want 1/ff", bus.data_valid, bus.data_out);
        else n_pass++;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.data_out, bus.data_valid, bus.frame_err, bus.parity_err, bus.overrun} !== 12'h000)
            $display("FAIL midframe_reset_outputs: got %h want 000",
                     {bus.data_out, bus.data_valid, bus.frame_err, bus.parity_err, bus.overrun});
        else n_pass++;
        n_total++;
        if (dut.state_q !== IDLE || dut.cnt_q !== 3'd0)
            $display("FAIL midframe_reset_fsm: state=%0d cnt=%0d want 0/0", dut.state_q, dut.cnt_q);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h5A)
            $display("FAIL after_reset_frame: valid=%b data=%h want 1/5a", bus.data_valid, bus.data_out);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        #1;
        test_reset();
        test_good_frame();
        test_frame_err();
        test_parity_err();
        test_overrun();
        test_simultaneous_drain();
        test_gaps_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
